// File: rtl/spi_pkg.sv
// Shared types for the spi_arbitro SPI master: FSM state encoding and
// SPI mode constants packed as {CKP,CPH}.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_TRANSFER = 3'd2,
      ST_HOLD     = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational one-hot requester pick. Round-robin from ptr by default;
// with SPI_ARB_PRIO_EN defined, fixed priority (lowest index wins, ptr ignored).
module spi_rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PW    = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    idx
);

`ifdef SPI_ARB_PRIO_EN
   always_comb begin
      gnt = '0;
      idx = '0;
      // Walk downwards so the lowest pending index is the last one written.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[PW'(k)]) begin
            gnt         = '0;
            gnt[PW'(k)] = 1'b1;
            idx         = PW'(k);
         end
      end
   end
`else
   int            s;
   logic          found;
   logic [PW-1:0] j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      s     = 0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         s = int'(ptr) + k;
         if (s >= N_REQ) s = s - N_REQ;
         j = PW'(s);
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
`endif

endmodule

// File: rtl/spi_arbitro.sv
// SPI master sharing one bus between N_REQ requesters with per-requester mode.
// Arbitration is round-robin unless SPI_ARB_PRIO_EN is defined (fixed priority).
module spi_arbitro
   import spi_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = 16,
   parameter int DIV   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       CKP,
   input  logic [N_REQ-1:0]       CPH,
   input  logic [N_REQ*WIDTH-1:0] tx_data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       rx_data,
   output logic                   SCK,
   output logic [N_REQ-1:0]       CS,
   output logic                   MOSI,
   input  logic                   MISO,
   output state_e                 dbg_state
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW = $clog2(2 * WIDTH);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d, cs_q, cs_d, arb_gnt;
   logic [PW-1:0]      idx_q, idx_d, ptr_q, ptr_d, arb_idx;
   logic               ckp_q, ckp_d, cph_q, cph_d, sck_q, sck_d;
   logic               mosi_q, mosi_d, done_q, done_d;
   logic [WIDTH-1:0]   shift_q, shift_d, rx_q, rx_d, tx_word;
   logic [DW-1:0]      div_q, div_d;
   logic [HW-1:0]      half_q, half_d;
   logic               half_end, fire, lead;

   spi_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      tx_word = tx_data[WIDTH-1:0];
      for (int k = 1; k < N_REQ; k++) begin
         if (arb_idx == PW'(k)) tx_word = tx_data[k*WIDTH +: WIDTH];
      end
   end

   assign half_end = (div_q == DW'(DIV - 1));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      ckp_d   = ckp_q;
      cph_d   = cph_q;
      shift_d = shift_q;
      div_d   = div_q;
      half_d  = half_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      rx_d    = rx_q;
      fire    = 1'b0;
      lead    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            if (|req) begin
               state_d = ST_SETUP;
               gnt_d   = arb_gnt;
               idx_d   = arb_idx;
               ckp_d   = CKP[arb_idx];
               cph_d   = CPH[arb_idx];
               shift_d = tx_word;
               sck_d   = CKP[arb_idx];
               cs_d    = ~arb_gnt;
               mosi_d  = tx_word[WIDTH-1];
            end
         end
         ST_SETUP: begin
            if (half_end) begin
               state_d = ST_TRANSFER;
               div_d   = '0;
               half_d  = '0;
               fire    = 1'b1;
               lead    = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_TRANSFER: begin
            if (half_end) begin
               div_d = '0;
               if (half_q == HW'(2 * WIDTH - 1)) begin
                  state_d = ST_HOLD;
               end else begin
                  // Half-period index h+1 is a leading edge when h is odd.
                  half_d = half_q + 1'b1;
                  fire   = 1'b1;
                  lead   = half_q[0];
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (half_end) begin
               state_d = ST_DONE;
               div_d   = '0;
               cs_d    = '1;
               done_d  = 1'b1;
               rx_d    = shift_q;
`ifndef SPI_ARB_PRIO_EN
               ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      // Sample on the edge selected by CPH, drive the next bit on the other.
      if (fire) begin
         sck_d = ~sck_q;
         if (lead ^ cph_q) shift_d = {shift_q[WIDTH-2:0], MISO};
         else              mosi_d  = shift_q[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         ckp_q   <= 1'b0;
         cph_q   <= 1'b0;
         shift_q <= '0;
         div_q   <= '0;
         half_q  <= '0;
         sck_q   <= 1'b0;
         cs_q    <= '1;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         ckp_q   <= ckp_d;
         cph_q   <= cph_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         half_q  <= half_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         rx_q    <= rx_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = |gnt_q;
   assign done      = done_q;
   assign rx_data   = rx_q;
   assign SCK       = sck_q;
   assign CS        = cs_q;
   assign MOSI      = mosi_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_arbitro.sv
// Directed bench for spi_arbitro (N_REQ=2, WIDTH=16, DIV=2) with a mode-0
// receptor slave on CS[0] and an optional MOSI->MISO loopback.
module tb_spi_arbitro;
   import spi_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  req = '0, CKP = '0, CPH = '0;
   logic [31:0] tx_data = '0;
   logic [1:0]  gnt, CS;
   logic        busy, done, SCK, MOSI, MISO;
   logic [15:0] rx_data;
   state_e      dbg_state;

   logic        loop = 1'b0;
   logic        s_miso = 1'b0;
   logic [15:0] s_sh = '0, s_rx = '0;

   int sck_rise = 0, cs0_low = 0, both_low = 0, done_cnt = 0;
   int n_cmp = 0, n_err = 0;

   assign MISO = loop ? MOSI : s_miso;

   always #5 clk = ~clk;

   spi_arbitro #(.N_REQ(2), .WIDTH(16), .DIV(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .CKP       (CKP),
      .CPH       (CPH),
      .tx_data   (tx_data),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .rx_data   (rx_data),
      .SCK       (SCK),
      .CS        (CS),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .dbg_state (dbg_state)
   );

   // Mode-0 receptor slave: preloaded word, captures on rising, shifts on falling.
   always @(negedge CS[0]) begin
      s_sh   = 16'h0106;
      s_miso = s_sh[15];
   end
   always @(posedge SCK) if (CS[0] === 1'b0) s_rx = {s_rx[14:0], MOSI};
   always @(negedge SCK) if (CS[0] === 1'b0) begin
      s_sh   = {s_sh[14:0], 1'b0};
      s_miso = s_sh[15];
   end

   always @(posedge SCK) sck_rise++;
   always @(posedge clk) begin
      if (CS[0] === 1'b0) cs0_low++;
      if (CS === 2'b00) both_low++;
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_gnt(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (gnt !== 2'b00) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      bit         ok;
      int         n, r0, c0, d0, b0;
      logic [1:0] modes [3];
      logic [1:0] exp_g;
      modes[0] = MODE1;
      modes[1] = MODE2;
      modes[2] = MODE3;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rx", 32'(rx_data), 0);
      chk("rst_sck", 32'(SCK), 0);
      chk("rst_cs", 32'(CS), 32'h3);
      chk("rst_mosi", 32'(MOSI), 0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b1;
      @(negedge clk);

      // Mode 0 against the receptor slave
      tx_data[15:0] = 16'hA5C3;
      req = 2'b01;
      r0 = sck_rise;
      c0 = cs0_low;
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_cs_setup", 32'(CS), 32'h2);
      chk("t1_sck_setup", 32'(SCK), 0);
      chk("t1_mosi_msb", 32'(MOSI), 1);
      req = 2'b00;
      wait_done(100, ok);
      chk("t1_done_seen", 32'(ok), 1);
      chk("t1_rx", 32'(rx_data), 32'h0106);
      chk("t1_cs_done", 32'(CS), 32'h3);
      chk("t1_gnt_in_done", 32'(gnt), 32'h1);
      chk("t1_slave_rx", 32'(s_rx), 32'hA5C3);
      chk("t1_cs_low_cycles", 32'(cs0_low - c0), 68);
      chk("t1_sck_rises", 32'(sck_rise - r0), 16);
      @(negedge clk);
      chk("t1_gnt_drop", 32'(gnt), 0);
      chk("t1_busy_drop", 32'(busy), 0);
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_rx_held", 32'(rx_data), 32'h0106);

      // Modes 1..3 with loopback
      loop = 1'b1;
      tx_data[15:0] = 16'h8001;
      for (int m = 0; m < 3; m++) begin
         CKP[0] = modes[m][1];
         CPH[0] = modes[m][0];
         req = 2'b01;
         @(negedge clk);
         chk("t2_sck_before", 32'(SCK), 32'(modes[m][1]));
         req = 2'b00;
         wait_done(100, ok);
         chk("t2_done_seen", 32'(ok), 1);
         chk("t2_rx", 32'(rx_data), 32'h8001);
         chk("t2_sck_done", 32'(SCK), 32'(modes[m][1]));
         @(negedge clk);
         chk("t2_sck_idle", 32'(SCK), 32'(modes[m][1]));
      end

      // Reset in the middle of the transfer, around bit 7
      loop = 1'b0;
      CKP = 2'b00;
      CPH = 2'b00;
      tx_data[15:0] = 16'hA5C3;
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      repeat (32) @(negedge clk);
      chk("t4_in_transfer", 32'(dbg_state), 32'(ST_TRANSFER));
      d0 = done_cnt;
      reset = 1'b0;
      @(negedge clk);
      chk("t4_cs", 32'(CS), 32'h3);
      chk("t4_sck", 32'(SCK), 0);
      chk("t4_gnt", 32'(gnt), 0);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b1;
      chk("t4_no_done", 32'(done_cnt - d0), 0);
      chk("t4_rx_cleared", 32'(rx_data), 0);
      loop = 1'b1;
      CPH[1] = 1'b1;
      tx_data[31:16] = 16'h3C5A;
      req = 2'b10;
      @(negedge clk);
      chk("t4_fresh_gnt", 32'(gnt), 32'h2);
      chk("t4_fresh_cs", 32'(CS), 32'h1);
      req = 2'b00;
      wait_done(100, ok);
      chk("t4_fresh_done_seen", 32'(ok), 1);
      chk("t4_fresh_rx", 32'(rx_data), 32'h3C5A);
      @(negedge clk);
      chk("t4_fresh_one_done", 32'(done_cnt - d0), 1);

      // Both requesters held high
      CPH = 2'b00;
      tx_data = {16'h5678, 16'h1234};
      b0 = both_low;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(10, n);
         chk("t3_gnt_gap", 32'(n), 1);
`ifdef SPI_ARB_PRIO_EN
         exp_g = 2'b01;
`else
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
         chk("t3_gnt_order", 32'(gnt), 32'(exp_g));
         wait_done(100, ok);
         chk("t3_done_seen", 32'(ok), 1);
         chk("t3_rx", 32'(rx_data), (exp_g == 2'b01) ? 32'h1234 : 32'h5678);
         if (k == 3) req = 2'b00;
         @(negedge clk);
         chk("t3_idle_gnt", 32'(gnt), 0);
      end
      @(negedge clk);
      chk("t3_stays_idle", 32'(gnt), 0);
      chk("t3_cs_both_low", 32'(both_low - b0), 0);

      // Inputs changed after grant are ignored
      loop = 1'b0;
      CKP = 2'b00;
      CPH = 2'b00;
      tx_data[15:0] = 16'hA5C3;
      d0 = done_cnt;
      req = 2'b01;
      @(negedge clk);
      chk("t5_gnt", 32'(gnt), 32'h1);
      tx_data[15:0] = 16'hFFFF;
      req = 2'b00;
      CKP = 2'b11;
      CPH = 2'b11;
      wait_done(100, ok);
      chk("t5_done_seen", 32'(ok), 1);
      chk("t5_rx", 32'(rx_data), 32'h0106);
      chk("t5_sck_mode_kept", 32'(SCK), 0);
      repeat (6) @(negedge clk);
      chk("t5_one_done", 32'(done_cnt - d0), 1);
      chk("t5_slave_rx", 32'(s_rx), 32'hA5C3);
      chk("t5_idle_gnt", 32'(gnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_arbitro.md
Name: spi_arbitro

Overview:
SPI master controller that shares one SPI bus between N_REQ requesters, each with its own slave select line.
- Arbitrates pending requests round-robin.
- Latches the winner's mode (CKP/CPH) and transmit word.
- Generates SCK, CS and MOSI, and samples MISO.
- Returns the received word with a one-cycle done pulse.
- Sits between the system's transaction sources and the receptor-type SPI slaves.

Parameters:
N_REQ, 2, number of requesters and slaves (2..4)
WIDTH, 16, bits per transaction
DIV, 2, clk cycles per SCK half-period (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  transaction request per requester, level
CKP  input  N_REQ  SCK idle polarity per requester
CPH  input  N_REQ  clock phase per requester
tx_data  input  N_REQ*WIDTH  transmit word; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  N_REQ  one-hot grant, held for the whole transaction
busy  output  1  high from grant until done inclusive
done  output  1  one-cycle pulse; rx_data valid in this cycle
rx_data  output  WIDTH  received word, held until the next done
SCK  output  1  serial clock
CS  output  N_REQ  active-low slave selects; at most one low
MOSI  output  1  serial out, MSB first
MISO  input  1  serial in, MSB first

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, gnt=0, busy=0, done=0, rx_data=0, SCK=0, CS=all 1, MOSI=0, RR pointer=0. Takes effect from any state and aborts any transfer; no done is produced.
- States: IDLE -> SETUP -> TRANSFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick the first requester at or after the RR pointer (wrap modulo N_REQ).
  - Latch its CKP, CPH and tx_data into the shift register, assert gnt[i] and busy, go to SETUP.
  - SCK rests at the last latched CKP (0 after reset).
- SETUP (DIV cycles):
  - CS[i]=0, SCK=CKP.
  - CPH=0: MOSI=shift[WIDTH-1] during SETUP.
- TRANSFER (2*WIDTH half-periods of DIV cycles each):
  - SCK toggles at every half-period boundary. The first toggle is the leading edge.
  - CPH=0: sample MISO on leading edges; shift out the next bit on trailing edges.
  - CPH=1: drive the next bit on leading edges; sample on trailing edges.
  - Samples shift into the LSB. The bit counter ends at WIDTH samples; SCK returns to CKP after the last edge.
- HOLD (DIV cycles): CS[i] still 0, SCK=CKP.
- DONE (1 cycle):
  - CS all 1, done=1, rx_data updated.
  - gnt and busy drop at the end of this cycle.
  - RR pointer becomes (i+1) mod N_REQ.
- Input stability:
  - req, CKP, CPH and tx_data changes after grant are ignored.
  - A requester that keeps req high is re-arbitrated in the next IDLE cycle. IDLE lasts at least one cycle between transactions.
- Latency: req to gnt is 1 cycle from IDLE. CS low time = (2 + 2*WIDTH)*DIV cycles.
- Simultaneous requests are resolved by the pointer only; no starvation.

Optional Feature:
SPI_ARB_PRIO_EN:
- Defined: fixed priority, lowest index wins; the RR pointer is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package spi_pkg: state encodings (IDLE, SETUP, TRANSFER, HOLD, DONE), mode constants MODE0..MODE3 as {CKP,CPH}.
- Sub-module spi_rr_arbiter: combinational one-hot pick from req plus pointer, with the SPI_ARB_PRIO_EN variant inside it.
- Top holds the FSM, divider counter, bit counter and shift register.

Test Plan:
1. Mode 0: req[0]=1, CKP=0, CPH=0, tx_data0=16'hA5C3, receptor-style slave preloaded 16'h0106 -> slave captures A5C3; rx_data=16'h0106 at done; CS[0] low exactly 68 cycles (DIV=2); 16 rising SCK edges.
2. Modes 1/2/3 with tx 16'h8001 on a looped-back MISO -> rx_data=16'h8001 for each; SCK idle equals CKP before and after.
3. req=2'b11 held -> grants alternate 0,1,0,1; CS never both low; one idle cycle between transactions (with SPI_ARB_PRIO_EN: grants always 0).
4. reset=0 mid-TRANSFER at bit 7 -> next cycle CS=2'b11, SCK=0, gnt=0, no done; a fresh req then completes normally.
5. tx_data0 changed to 16'hFFFF and req dropped after grant -> transmitted word still A5C3; done still pulses once.
